// File: rtl/dutb_run_monitor.sv
// Run-control / progress monitor for the dutb environment.
// Sequences the DUT reset, tallies completed and failed items over P_CH
// scoreboard channels, pulses a milestone every P_MILESTONE_LENGTH items and
// ends the run with a sticky stop (fail limit) or done (item target).
// Handshake: item_vld[i] is a one-cycle strobe with no back-pressure; item_pass[i]
// is only meaningful while item_vld[i] is high, and strobes are only accepted in RUN.
// state_dbg mirrors the FSM state encoding for external checkers.
module dutb_run_monitor #(
  parameter int unsigned P_CH               = 4,
  parameter int unsigned P_CNT_W            = 16,
  parameter int unsigned P_RST_LENGTH       = 33,
  parameter int unsigned P_MAX_FAIL_NUM     = 16,
  parameter int unsigned P_MILESTONE_LENGTH = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [P_CNT_W-1:0]        target,
  input  logic [P_CH-1:0]           item_vld,
  input  logic [P_CH-1:0]           item_pass,
  output logic                      dut_rst,
  output logic                      running,
  output logic                      milestone,
  output logic                      done,
  output logic                      stop,
  output logic [P_CNT_W-1:0]        total_cnt,
  output logic [P_CNT_W-1:0]        fail_cnt,
  output logic [P_CH*P_CNT_W-1:0]   ch_fail_cnt,
  output logic [2:0]                state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RST_HOLD = 3'd1,
    S_RUN      = 3'd2,
    S_DONE     = 3'd3,
    S_FAIL     = 3'd4
  } state_t;

  localparam int unsigned HOLD_W = $clog2(P_RST_LENGTH + 1);
  localparam int unsigned N_W    = $clog2(P_CH + 1);
  localparam int unsigned ACC_W  = $clog2(P_MILESTONE_LENGTH + P_CH + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(P_RST_LENGTH - 1);

  state_t               state, state_next;
  logic [HOLD_W-1:0]    hold_cnt;
  logic [P_CNT_W-1:0]   tgt_q;
  logic [ACC_W-1:0]     acc;
  logic [P_CNT_W-1:0]   ch_fail_q [P_CH];

  logic [N_W-1:0]       n_items;
  logic [N_W-1:0]       n_fails;
  logic [P_CNT_W:0]     total_sum;
  logic [P_CNT_W:0]     fail_sum;
  logic [P_CNT_W-1:0]   total_next;
  logic [P_CNT_W-1:0]   fail_next;
  logic [ACC_W:0]       acc_sum;
  logic                 ms_hit;
  logic [ACC_W-1:0]     acc_next;

  assign state_dbg = state;

  // Flatten per-channel fail counters onto the packed output, ch0 in the LSBs.
  always_comb begin
    ch_fail_cnt = '0;
    for (int i = 0; i < P_CH; i++) begin
      ch_fail_cnt[i*P_CNT_W +: P_CNT_W] = ch_fail_q[i];
    end
  end

  // Per-cycle item/fail popcounts, saturating sums and milestone accumulator.
  always_comb begin
    n_items = '0;
    n_fails = '0;
    for (int i = 0; i < P_CH; i++) begin
      n_items = n_items + N_W'(item_vld[i]);
      n_fails = n_fails + N_W'(item_vld[i] & ~item_pass[i]);
    end
    total_sum  = {1'b0, total_cnt} + (P_CNT_W+1)'(n_items);
    fail_sum   = {1'b0, fail_cnt} + (P_CNT_W+1)'(n_fails);
    total_next = total_sum[P_CNT_W] ? '1 : total_sum[P_CNT_W-1:0];
    fail_next  = fail_sum[P_CNT_W] ? '1 : fail_sum[P_CNT_W-1:0];
    acc_sum    = (ACC_W+1)'(acc) + (ACC_W+1)'(n_items);
    ms_hit     = (P_MILESTONE_LENGTH != 0) &&
                 (acc_sum >= (ACC_W+1)'(P_MILESTONE_LENGTH));
    if (P_MILESTONE_LENGTH == 0) begin
      acc_next = '0;
    end else if (ms_hit) begin
      acc_next = ACC_W'(acc_sum - (ACC_W+1)'(P_MILESTONE_LENGTH));
    end else begin
      acc_next = ACC_W'(acc_sum);
    end
  end

  // Next-state logic; termination looks at the registered (already updated) counts.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:     if (start) state_next = S_RST_HOLD;
      S_RST_HOLD: if (hold_cnt == HOLD_LAST) state_next = S_RUN;
      S_RUN: begin
        if ((P_MAX_FAIL_NUM != 0) && (32'(fail_cnt) >= P_MAX_FAIL_NUM)) begin
          state_next = S_FAIL;
        end else if ((tgt_q != '0) && (total_cnt >= tgt_q)) begin
          state_next = S_DONE;
        end
      end
      S_DONE:     if (start) state_next = S_RST_HOLD;
      S_FAIL:     if (start) state_next = S_RST_HOLD;
      default:    state_next = S_IDLE;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      hold_cnt  <= '0;
      tgt_q     <= '0;
      acc       <= '0;
      total_cnt <= '0;
      fail_cnt  <= '0;
      for (int i = 0; i < P_CH; i++) ch_fail_q[i] <= '0;
      milestone <= 1'b0;
      dut_rst   <= 1'b1;
      running   <= 1'b0;
      done      <= 1'b0;
      stop      <= 1'b0;
    end else begin
      state     <= state_next;
      milestone <= 1'b0;
      dut_rst   <= (state_next == S_IDLE) || (state_next == S_RST_HOLD);
      running   <= (state_next == S_RUN);
      done      <= (state_next == S_DONE);
      stop      <= (state_next == S_FAIL);
      if ((state_next == S_RST_HOLD) && (state != S_RST_HOLD)) begin
        // Fresh run: nothing from the previous run may leak into this one.
        hold_cnt  <= '0;
        tgt_q     <= target;
        acc       <= '0;
        total_cnt <= '0;
        fail_cnt  <= '0;
        for (int i = 0; i < P_CH; i++) ch_fail_q[i] <= '0;
      end else if (state == S_RST_HOLD) begin
        hold_cnt <= hold_cnt + 1'b1;
      end else if (state == S_RUN) begin
        // Items in the cycle that leaves RUN are still counted here.
        total_cnt <= total_next;
        fail_cnt  <= fail_next;
        acc       <= acc_next;
        milestone <= ms_hit;
        for (int i = 0; i < P_CH; i++) begin
          if (item_vld[i] && !item_pass[i] && (ch_fail_q[i] != '1)) begin
            ch_fail_q[i] <= ch_fail_q[i] + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dutb_run_monitor.sv
// Directed bench for dutb_run_monitor: reset hold timing, milestones,
// target completion, fail stop, fail/target priority and reset mid-run.
module tb_dutb_run_monitor;

  localparam int CH = 4;
  localparam int W  = 16;

  logic            clk;
  logic            rst;
  logic            start;
  logic [W-1:0]    target;
  logic [CH-1:0]   item_vld;
  logic [CH-1:0]   item_pass;
  logic            dut_rst;
  logic            running;
  logic            milestone;
  logic            done;
  logic            stop;
  logic [W-1:0]    total_cnt;
  logic [W-1:0]    fail_cnt;
  logic [CH*W-1:0] ch_fail_cnt;
  logic [2:0]      state_dbg;

  int errors = 0;
  int checks = 0;

  dutb_run_monitor dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .target      (target),
    .item_vld    (item_vld),
    .item_pass   (item_pass),
    .dut_rst     (dut_rst),
    .running     (running),
    .milestone   (milestone),
    .done        (done),
    .stop        (stop),
    .total_cnt   (total_cnt),
    .fail_cnt    (fail_cnt),
    .ch_fail_cnt (ch_fail_cnt),
    .state_dbg   (state_dbg)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver tasks: inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [W-1:0] tgt);
    start  = 1'b1;
    target = tgt;
    tick();
    start  = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Counts cycles with running low after the start edge; bounded at 200.
  task automatic wait_run(output int hold, output bit rst_ok);
    hold   = 0;
    rst_ok = 1'b1;
    while (running !== 1'b1 && hold < 200) begin
      if (dut_rst !== 1'b1) rst_ok = 1'b0;
      hold++;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (dut_rst !== 1'b1)   begin errors++; $display("FAIL reset_dut_rst: got %0b expected 1", dut_rst); end
    checks++; if (running !== 1'b0)   begin errors++; $display("FAIL reset_running: got %0b expected 0", running); end
    checks++; if ({milestone, done, stop} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {milestone, done, stop}); end
    checks++; if (total_cnt !== 16'd0 || fail_cnt !== 16'd0) begin errors++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", total_cnt, fail_cnt); end
    checks++; if (ch_fail_cnt !== '0) begin errors++; $display("FAIL reset_ch_fail: got %h expected 0", ch_fail_cnt); end
    checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_dbg); end
    rst = 1'b0;
    tick();
    checks++; if (dut_rst !== 1'b1 || running !== 1'b0) begin errors++; $display("FAIL idle_hold: got dut_rst=%0b running=%0b expected 1/0", dut_rst, running); end
  endtask

  task automatic test_rst_hold();
    int hold;
    bit rst_ok;
    pulse_start(16'd0);
    wait_run(hold, rst_ok);
    checks++; if (hold !== 33)        begin errors++; $display("FAIL hold_len: got %0d expected 33", hold); end
    checks++; if (rst_ok !== 1'b1)    begin errors++; $display("FAIL hold_dut_rst: got dropout expected dut_rst high throughout"); end
    checks++; if (dut_rst !== 1'b0 || running !== 1'b1) begin errors++; $display("FAIL run_entry: got dut_rst=%0b running=%0b expected 0/1", dut_rst, running); end
  endtask

  task automatic test_milestones();
    int pulses = 0;
    for (int k = 1; k <= 25; k++) begin
      item_vld  = 4'b0001;
      item_pass = 4'b0001;
      tick();
      if (milestone === 1'b1) pulses++;
      if (k == 10 || k == 20) begin
        checks++; if (milestone !== 1'b1) begin errors++; $display("FAIL milestone_at_%0d: got %0b expected 1", k, milestone); end
      end
    end
    item_vld = '0;
    tick();
    checks++; if (pulses !== 2)          begin errors++; $display("FAIL milestone_count: got %0d expected 2", pulses); end
    checks++; if (milestone !== 1'b0)    begin errors++; $display("FAIL milestone_idle: got %0b expected 0", milestone); end
    checks++; if (total_cnt !== 16'd25)  begin errors++; $display("FAIL ms_total: got %0d expected 25", total_cnt); end
    checks++; if (fail_cnt !== 16'd0)    begin errors++; $display("FAIL ms_fail: got %0d expected 0", fail_cnt); end
  endtask

  task automatic test_target();
    int hold;
    bit rst_ok;
    pulse_rst();
    pulse_start(16'd8);
    wait_run(hold, rst_ok);
    item_vld  = 4'b1111;
    item_pass = 4'b1111;
    tick();
    tick();
    item_vld = '0;
    checks++; if (total_cnt !== 16'd8 || done !== 1'b0) begin errors++; $display("FAIL tgt_count: got total=%0d done=%0b expected 8/0", total_cnt, done); end
    tick();
    checks++; if (done !== 1'b1 || running !== 1'b0 || stop !== 1'b0) begin errors++; $display("FAIL tgt_done: got done=%0b running=%0b stop=%0b expected 1/0/0", done, running, stop); end
    item_vld = 4'b1111;
    tick();
    tick();
    item_vld = '0;
    tick();
    checks++; if (total_cnt !== 16'd8 || done !== 1'b1) begin errors++; $display("FAIL tgt_dropped: got total=%0d done=%0b expected 8/1", total_cnt, done); end
  endtask

  task automatic test_fail_stop();
    int hold;
    bit rst_ok;
    pulse_start(16'd0);
    checks++; if (total_cnt !== 16'd0 || done !== 1'b0 || dut_rst !== 1'b1) begin errors++; $display("FAIL restart_clear: got total=%0d done=%0b dut_rst=%0b expected 0/0/1", total_cnt, done, dut_rst); end
    wait_run(hold, rst_ok);
    checks++; if (hold !== 33) begin errors++; $display("FAIL restart_hold: got %0d expected 33", hold); end
    item_vld  = 4'b1111;
    item_pass = 4'b0000;
    repeat (4) tick();
    item_vld = '0;
    checks++; if (fail_cnt !== 16'd16 || total_cnt !== 16'd16 || stop !== 1'b0) begin errors++; $display("FAIL fail_counts: got fail=%0d total=%0d stop=%0b expected 16/16/0", fail_cnt, total_cnt, stop); end
    tick();
    checks++; if (stop !== 1'b1 || running !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL fail_stop: got stop=%0b running=%0b done=%0b expected 1/0/0", stop, running, done); end
    for (int i = 0; i < CH; i++) begin
      checks++; if (ch_fail_cnt[i*W +: W] !== 16'd4) begin errors++; $display("FAIL ch_fail_%0d: got %0d expected 4", i, ch_fail_cnt[i*W +: W]); end
    end
  endtask

  task automatic test_fail_wins();
    int hold;
    bit rst_ok;
    pulse_start(16'd16);
    wait_run(hold, rst_ok);
    item_vld  = 4'b1111;
    item_pass = 4'b0000;
    repeat (4) tick();
    item_vld = '0;
    tick();
    checks++; if (stop !== 1'b1 || done !== 1'b0 || running !== 1'b0) begin errors++; $display("FAIL fail_wins: got stop=%0b done=%0b running=%0b expected 1/0/0", stop, done, running); end
  endtask

  task automatic test_rst_mid_run();
    int hold;
    bit rst_ok;
    pulse_start(16'd0);
    wait_run(hold, rst_ok);
    item_vld  = 4'b1111;
    item_pass = 4'b1111;
    tick();
    item_vld = 4'b0111;
    tick();
    item_vld = '0;
    checks++; if (total_cnt !== 16'd7) begin errors++; $display("FAIL mid_total: got %0d expected 7", total_cnt); end
    pulse_rst();
    checks++; if (total_cnt !== 16'd0 || dut_rst !== 1'b1 || running !== 1'b0 || state_dbg !== 3'd0) begin errors++; $display("FAIL mid_rst: got total=%0d dut_rst=%0b running=%0b state=%0d expected 0/1/0/0", total_cnt, dut_rst, running, state_dbg); end
    tick();
    pulse_start(16'd0);
    item_vld  = 4'b1111;
    item_pass = 4'b0000;
    tick();
    tick();
    item_vld = '0;
    wait_run(hold, rst_ok);
    checks++; if (hold + 2 !== 33) begin errors++; $display("FAIL mid_hold: got %0d expected 33", hold + 2); end
    checks++; if (total_cnt !== 16'd0 || fail_cnt !== 16'd0 || ch_fail_cnt !== '0) begin errors++; $display("FAIL hold_strobe: got total=%0d fail=%0d expected 0/0", total_cnt, fail_cnt); end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    target    = '0;
    item_vld  = '0;
    item_pass = '0;
    test_reset();
    test_rst_hold();
    test_milestones();
    test_target();
    test_fail_stop();
    test_fail_wins();
    test_rst_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
